// File: rtl/lut_block_cfg_if.sv
// Bus bundle for lut_block_cfg: serial config chain plus the LUT address/result lanes.
// The master side drives configuration and addresses; the slave side is the logic block.
interface lut_block_cfg_if #(
    parameter int K       = 5,
    parameter int NUM_LUT = 2
);
    logic                   cfg_start;
    logic                   cfg_en;
    logic                   cfg_in;
    logic                   cfg_out;
    logic                   cfg_done;
    logic [NUM_LUT*K-1:0]   lut_in;
    logic [NUM_LUT-1:0]     lut_out;

    modport master (
        output cfg_start, cfg_en, cfg_in, lut_in,
        input  cfg_out, cfg_done, lut_out
    );

    modport slave (
        input  cfg_start, cfg_en, cfg_in, lut_in,
        output cfg_out, cfg_done, lut_out
    );
endinterface

// File: rtl/lut_block_cfg.sv
// Configurable logic block: NUM_LUT K-input LUTs loaded from a bit-serial chain.
// Each LUT selects between its combinational result and a registered copy.
module lut_block_lane #(
    parameter int K = 5,
    localparam int N = 1 << K
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N:0]   cfg,
    input  logic [K-1:0] addr,
    input  logic         clr,
    input  logic         done,
    output logic         out
);
    logic [N-1:0] truth;
    logic         reg_sel;
    logic         comb;
    logic         ff;

    assign truth   = cfg[N-1:0];
    assign reg_sel = cfg[N];
    assign comb    = truth[addr];

    // The flop only tracks the LUT once configured, so the first registered
    // result reflects the address sampled on the first edge in DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  ff <= 1'b0;
        else if (clr)  ff <= 1'b0;
        else if (done) ff <= comb;
    end

    assign out = done ? (reg_sel ? ff : comb) : 1'b0;
endmodule

module lut_block_cfg #(
    parameter int K       = 5,
    parameter int NUM_LUT = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    lut_block_cfg_if.slave bus
);
    localparam int LUT_BITS = (1 << K) + 1;
    localparam int CFG_BITS = NUM_LUT * LUT_BITS;
    localparam int CW       = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [CFG_BITS-1:0] chain;
    logic                shift;
    logic                done;
    logic [NUM_LUT-1:0]  lut_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A start pulse wins over a shift in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift     = 1'b0;
        if (bus.cfg_start) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
        end else if (state == LOAD && bus.cfg_en) begin
            shift   = 1'b1;
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(CFG_BITS - 1)) state_nxt = DONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   chain <= '0;
        else if (shift) chain <= {chain[CFG_BITS-2:0], bus.cfg_in};
    end

    assign done         = (state == DONE);
    assign bus.cfg_done = done;
    assign bus.cfg_out  = chain[CFG_BITS-1];

    for (genvar j = 0; j < NUM_LUT; j++) begin : g_lane
        lut_block_lane #(.K(K)) u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .cfg     (chain[j*LUT_BITS +: LUT_BITS]),
            .addr    (bus.lut_in[j*K +: K]),
            .clr     (bus.cfg_start),
            .done    (done),
            .out     (lut_out[j])
        );
    end

    assign bus.lut_out = lut_out;
endmodule
